// File: rtl/scan_pkg.sv
// Shared constants and types for the scan arbiter and the LED-scan controller
// that reuses its rotate-priority picker.
package scan_pkg;

  localparam int N                  = 8;
  localparam int IDX_W              = 3;
  localparam int PRESCALE_W_DEFAULT = 25;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: returns the first requester at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick
  import scan_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;

  // Doubling the vector turns the modulo scan into a plain part-select.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: N];

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    found = 1'b0;
    idx   = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        found = 1'b1;
        idx   = ptr + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/scan_arbiter.sv
// Round-robin arbiter that time-shares one resource among N requesters,
// granting on slow prescaler ticks and bounding each hold to HOLD_TICKS ticks.
module scan_arbiter
  import scan_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEFAULT,
  parameter int HOLD_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             tick
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  logic [PRESCALE_W-1:0] presc;
  state_t                state;
  logic [IDX_W-1:0]      ptr;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  hold_expired;
  logic                  rel_now;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc + PRESCALE_W'(1);
      tick  <= &presc;
    end
  end

  assign hold_expired = tick && (hold_cnt == HOLD_W'(HOLD_TICKS - 1));
  // Owner dropping its request and the final tick collapse into one release.
  assign rel_now      = (state == GRANT) && (!req[grant_idx] || hold_expired);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick && pick_found) begin
            grant       <= N'(1) << pick_idx;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (rel_now) begin
            // grant_idx is left alone so downstream still sees the last owner.
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + IDX_W'(1);
            state       <= IDLE;
          end else if (tick) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_arbiter.sv
// Self-checking bench for scan_arbiter: directed scenarios plus random request
// traffic, all compared cycle by cycle against a behavioural model.
module tb_scan_arbiter;

  localparam int PW     = 4;
  localparam int HOLD   = 2;
  localparam int PERIOD = 1 << PW;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = '0;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: owner is -1 when the resource is idle.
  int m_owner;
  int m_ptr;
  int m_ticks_owned;
  int m_edges;
  int m_last;
  bit m_tick;

  scan_arbiter #(
    .PRESCALE_W (PW),
    .HOLD_TICKS (HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner       = -1;
    m_ptr         = 0;
    m_ticks_owned = 0;
    m_edges       = 0;
    m_tick        = 1'b0;
    m_last        = 0;
  endtask

  // One clock edge of the specified behaviour, using the tick visible before the edge.
  task automatic model_edge(input logic [7:0] r);
    if (m_owner < 0) begin
      if (m_tick && r != 8'h00) begin
        m_owner       = pick(r, m_ptr);
        m_last        = m_owner;
        m_ticks_owned = 0;
      end
    end else if (!r[m_owner] || (m_tick && m_ticks_owned + 1 == HOLD)) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (m_tick) begin
      m_ticks_owned++;
    end
    m_edges++;
    m_tick = (m_edges % PERIOD == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(req);
    #1;
    check("grant", grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("grant_valid", grant_valid, (m_owner >= 0) ? 32'd1 : 32'd0);
    check("grant_idx", grant_idx, m_last);
    check("tick", tick, m_tick);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    #3;
    check("rst_grant", grant, 0);
    check("rst_valid", grant_valid, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_until_owned(input int budget);
    int i = 0;
    while (m_owner < 0 && i < budget) begin
      step();
      i++;
    end
    check("owned_in_budget", grant_valid, 1);
  endtask

  initial begin
    int first_owner;
    int n_rise;
    int cyc;
    int rise0;
    int fall0;
    int wait_cyc;
    bit prev_valid;

    model_reset();

    // Asynchronous reset while owner 3 holds the grant, then ptr restarts at 0.
    do_reset();
    req = 8'h08;
    run_until_owned(40);
    check("owner3_grant", grant, 8'h08);
    for (int i = 0; i < 3; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_valid", grant_valid, 0);
    check("async_rst_idx", grant_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req = 8'hFF;
    run_until_owned(40);
    check("ptr_after_reset", grant_idx, 0);

    // Single requester held continuously.
    do_reset();
    req = 8'h10;
    for (int i = 0; i < 120; i++) step();

    // Rotation with wrap, grant length and idle gap.
    do_reset();
    req        = 8'hFF;
    n_rise     = 0;
    cyc        = 0;
    rise0      = 0;
    fall0      = 0;
    prev_valid = 1'b0;
    while (n_rise < 9 && cyc < 700) begin
      step();
      cyc++;
      if (grant_valid && !prev_valid) begin
        check($sformatf("rotation_%0d", n_rise), grant_idx, n_rise % 8);
        if (n_rise == 0) rise0 = cyc;
        if (n_rise == 1) check("idle_gap", cyc - fall0, PERIOD);
        n_rise++;
      end
      if (!grant_valid && prev_valid && n_rise == 1) begin
        fall0 = cyc;
        check("grant_length", fall0 - rise0, HOLD * PERIOD);
      end
      prev_valid = grant_valid;
    end
    check("rotation_count", n_rise, 9);

    // Early release by owner 2, then wrap past 3..7 to requester 0.
    do_reset();
    req = 8'h04;
    run_until_owned(40);
    check("early_owner", grant_idx, 2);
    for (int i = 0; i < 3; i++) step();
    req = 8'h00;
    step();
    check("early_release", grant, 0);
    req = 8'h05;
    run_until_owned(40);
    check("early_next_owner", grant_idx, 0);

    // Request drop coinciding with the expiring tick.
    do_reset();
    req = 8'hFF;
    run_until_owned(40);
    first_owner = m_owner;
    for (int i = 0; i < 100; i++) begin
      if (m_owner >= 0 && m_tick && m_ticks_owned + 1 == HOLD) break;
      step();
    end
    req = 8'h00;
    step();
    check("simul_release", grant_valid, 0);
    for (int i = 0; i < PERIOD + 2; i++) step();
    req = 8'hFF;
    run_until_owned(40);
    check("simul_ptr", grant_idx, (first_owner + 1) % 8);

    // Request arriving one cycle after a tick waits for the following tick.
    do_reset();
    req = 8'h00;
    for (int i = 0; i < 40 && !m_tick; i++) step();
    step();
    req      = 8'h80;
    wait_cyc = 0;
    while (!grant_valid && wait_cyc < 40) begin
      step();
      wait_cyc++;
    end
    check("late_wait", wait_cyc, PERIOD);
    check("late_grant", grant, 8'h80);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = 8'(1 << $urandom_range(0, 7));
          1:       req = 8'($urandom) & 8'($urandom);
          2:       req = 8'h00;
          default: req = 8'($urandom);
        endcase
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
